module_barrido_4_digitos: RTL and testbench
===========================================

MODULE_BARRIDO_4_DIGITOS -- requirements
Module: module_barrido_4_digitos

Interface
REQ-001 SHALL provide parameter: CUENTA_REFRESCO, 4, number of clk cycles each digit is lit (legal range 1..2^20).
REQ-002 SHALL provide parameter: CUENTA_APAGADO, 2, number of clk cycles all digits are dark between digits (legal range 1..2^20).
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port: en  input  1  1 = scanning runs; 0 = display dark, scan halted.
REQ-006 SHALL provide port: mask  input  4  per-digit enable; bit i = 1 includes digit i in the scan.
REQ-007 SHALL provide port: sel  output  2  index of current digit; drives the sel input of the 4:1 data mux (mux input a = 0, b = 1, c = 2, d = 3).
REQ-008 SHALL provide port: an  output  4  digit anodes, active-low, at most one bit low.
REQ-009 SHALL provide port: tick  output  1  one-cycle pulse marking each sel advance.

Function
REQ-010 SHALL implement FSM states IDLE, SHOW and BLANK, with a single down/up counter sized for max(CUENTA_REFRESCO, CUENTA_APAGADO).
REQ-011 SHALL register all outputs; an, sel and tick change only on a clk edge or on rst.
REQ-012 IDLE: an = 4'b1111 and tick = 0; if en = 1 and mask != 0, SHALL go to SHOW next cycle with sel = first enabled index at or after the current sel, wrapping 3->0.
REQ-013 SHOW: an[sel] = 0 and the other anode bits = 1, held for exactly CUENTA_REFRESCO cycles, then the FSM SHALL go to BLANK.
REQ-014 BLANK: an = 4'b1111 for exactly CUENTA_APAGADO cycles, then the FSM SHALL go to SHOW.
REQ-015 On the BLANK->SHOW transition, sel SHALL advance to the next enabled index after sel, in round-robin order 0,1,2,3,0.
REQ-016 tick SHALL be 1 only in the cycle in which the new sel first appears.
REQ-017 With exactly one mask bit set, sel SHALL remain on that index, the SHOW/BLANK alternation SHALL continue, and tick SHALL still pulse on each BLANK->SHOW.
REQ-018 If mask[sel] goes 0 during SHOW, an SHALL go 4'b1111 on the next cycle, the counter SHALL keep running, and the next advance SHALL skip that index.
REQ-019 If en = 0 or mask = 0 in SHOW or BLANK, the FSM SHALL go to IDLE next cycle with an = 4'b1111 and sel held.
REQ-020 On leaving IDLE, scanning SHALL resume from the held sel per REQ-012.
REQ-021 The counter SHALL reload to 0 on every state change, so no partial dwell carries over.
REQ-022 When en and mask are both stable, the period per enabled digit SHALL be exactly CUENTA_REFRESCO + CUENTA_APAGADO cycles.
REQ-023 The block SHALL never drive two an bits low simultaneously, including across reset and mask changes.

Reset
REQ-024 While rst = 1, the block SHALL hold state = IDLE, counter = 0, sel = 2'b00, an = 4'b1111 and tick = 0, independent of clk.
REQ-025 rst assertion mid-SHOW or mid-BLANK SHALL blank an immediately (asynchronously).
REQ-026 After rst deasserts, the first possible transition SHALL be at the first clk rising edge, following REQ-012.

Verification (CUENTA_REFRESCO = 4, CUENTA_APAGADO = 2)
REQ-027 Reset check: drive rst = 1 with en = 1 and mask = 4'b1111, then release rst -> an = 1111 and sel = 00 during reset; an = 1110 for 4 cycles, 1111 for 2, then 1101 with sel = 01 and tick = 1 for one cycle; the sequence 0,1,2,3,0 follows with a 6-cycle period.
REQ-028 Mask skip: mask = 4'b0101 -> sel alternates 00 and 10; an alternates 1110 and 1011 with 2-cycle blanking between them; indices 1 and 3 never appear.
REQ-029 Mid-SHOW mask drop: clear mask[2] while sel = 10 and an = 1011 -> an = 1111 next cycle; the next sel is 11.
REQ-030 Halt/resume: deassert en during BLANK after sel = 01 -> next cycle is IDLE with an = 1111 and sel = 01 held; reassert en -> an = 1101 next cycle.
REQ-031 Empty mask and single digit: mask = 0000 -> IDLE, an = 1111, tick never 1; mask = 1000 -> sel = 11 constant, an toggles between 0111 (4 cycles) and 1111 (2 cycles), tick pulses every 6 cycles.
REQ-032 Async reset: assert rst between clock edges while an = 1011 -> an = 1111 and sel = 00 before the next clk edge.
REQ-033 The bench SHALL check on every cycle of every scenario that an never has more than one bit at 0.

Source files
------------

// File: rtl/module_barrido_4_digitos.sv
// Four-digit multiplexed display scanner: lights one enabled digit at a time
// with a dark gap between digits, and reports the current digit on sel.
module module_barrido_4_digitos #(
    parameter int CUENTA_REFRESCO = 4,
    parameter int CUENTA_APAGADO  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       tick
);

    localparam int CUENTA_MAX = (CUENTA_REFRESCO > CUENTA_APAGADO) ? CUENTA_REFRESCO : CUENTA_APAGADO;
    localparam int CW = (CUENTA_MAX > 1) ? $clog2(CUENTA_MAX) : 1;
    localparam logic [CW-1:0] FIN_REFRESCO = CW'(CUENTA_REFRESCO - 1);
    localparam logic [CW-1:0] FIN_APAGADO  = CW'(CUENTA_APAGADO - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} estado_t;

    estado_t       estado;
    logic [CW-1:0] cuenta;
    logic [1:0]    sel_reanudar;
    logic [1:0]    sel_avanzar;
    logic          activo;

    // Round-robin search for the first enabled digit, starting at base
    // itself (incluir = 1) or just after it (incluir = 0).
    function automatic logic [1:0] buscar(input logic [1:0] base, input logic [3:0] m,
                                          input logic incluir);
        logic [1:0] idx;
        logic       hallado;
        buscar  = base;
        hallado = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i) + (incluir ? 2'd0 : 2'd1);
            if (!hallado && m[idx]) begin
                buscar  = idx;
                hallado = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] anodo(input logic [1:0] s);
        anodo = ~(4'b0001 << s);
    endfunction

    assign activo       = en && (mask != 4'b0000);
    assign sel_reanudar = buscar(sel, mask, 1'b1);
    assign sel_avanzar  = buscar(sel, mask, 1'b0);

    // Every state change reloads the counter, so dwell times always start fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
            cuenta <= '0;
            sel    <= 2'b00;
            an     <= 4'b1111;
            tick   <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (estado)
                IDLE: begin
                    cuenta <= '0;
                    an     <= 4'b1111;
                    if (activo) begin
                        estado <= SHOW;
                        sel    <= sel_reanudar;
                        an     <= anodo(sel_reanudar);
                        tick   <= (sel_reanudar != sel);
                    end
                end
                SHOW: begin
                    if (!activo) begin
                        estado <= IDLE;
                        cuenta <= '0;
                        an     <= 4'b1111;
                    end else if (cuenta == FIN_REFRESCO) begin
                        estado <= BLANK;
                        cuenta <= '0;
                        an     <= 4'b1111;
                    end else begin
                        // A digit masked off mid-dwell goes dark but keeps its time slot.
                        cuenta <= cuenta + 1'b1;
                        an     <= mask[sel] ? anodo(sel) : 4'b1111;
                    end
                end
                BLANK: begin
                    an <= 4'b1111;
                    if (!activo) begin
                        estado <= IDLE;
                        cuenta <= '0;
                    end else if (cuenta == FIN_APAGADO) begin
                        estado <= SHOW;
                        cuenta <= '0;
                        sel    <= sel_avanzar;
                        an     <= anodo(sel_avanzar);
                        tick   <= 1'b1;
                    end else begin
                        cuenta <= cuenta + 1'b1;
                    end
                end
                default: begin
                    estado <= IDLE;
                    cuenta <= '0;
                    an     <= 4'b1111;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_barrido_4_digitos.sv
// Directed self-checking bench for the four-digit scanner (refresh 4, blank 2).
module tb_module_barrido_4_digitos;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [1:0] sel;
    logic [3:0] an;
    logic       tick;

    int checks = 0;
    int failures = 0;

    module_barrido_4_digitos #(.CUENTA_REFRESCO(4), .CUENTA_APAGADO(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mask(mask), .sel(sel), .an(an), .tick(tick)
    );

    always #5 clk = ~clk;

    // At most one anode may ever be low, in every scenario and during reset.
    always @(negedge clk) begin
        checks++;
        if ($countones(~an) > 1) begin
            failures++;
            $display("[TB] FAIL an_onehot t=%0t an=%b required at most one low bit", $time, an);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    // Hold reset for one cycle with the given inputs, release at a falling edge.
    task automatic do_reset(input logic en_v, input logic [3:0] mask_v);
        @(negedge clk);
        rst  = 1'b1;
        en   = en_v;
        mask = mask_v;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle k after reset release: 6-cycle period per digit, 4 lit then 2 dark.
    task automatic test_reset;
        logic [1:0] es;
        logic [3:0] ea;
        logic       et;
        int p, ph;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; mask = 4'b1111;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111 || sel !== 2'b00 || tick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold an=%b sel=%b tick=%b required 1111 00 0", an, sel, tick);
        end
        rst = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            p  = (k - 1) / 6;
            ph = (k - 1) % 6;
            es = 2'(p % 4);
            ea = (ph < 4) ? ~(4'b0001 << es) : 4'b1111;
            et = (ph == 0 && k > 1);
            checks++;
            if (an !== ea || sel !== es || tick !== et) begin
                failures++;
                $display("[TB] FAIL reset_seq k=%0d an=%b sel=%b tick=%b required %b %b %b", k, an, sel, tick, ea, es, et);
            end
        end
    endtask

    task automatic test_mask_skip;
        logic [1:0] es;
        logic [3:0] ea;
        logic       et;
        int p, ph;
        do_reset(1'b1, 4'b0101);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            p  = (k - 1) / 6;
            ph = (k - 1) % 6;
            es = (p % 2 == 0) ? 2'd0 : 2'd2;
            ea = (ph < 4) ? ((es == 2'd0) ? 4'b1110 : 4'b1011) : 4'b1111;
            et = (ph == 0 && k > 1);
            checks++;
            if (an !== ea || sel !== es || tick !== et) begin
                failures++;
                $display("[TB] FAIL mask_skip k=%0d an=%b sel=%b tick=%b required %b %b %b", k, an, sel, tick, ea, es, et);
            end
        end
    endtask

    task automatic test_mask_drop;
        do_reset(1'b1, 4'b1111);
        repeat (13) @(negedge clk);
        checks++;
        if (an !== 4'b1011 || sel !== 2'd2) begin
            failures++;
            $display("[TB] FAIL drop_pre an=%b sel=%b required 1011 10", an, sel);
        end
        mask = 4'b1011;
        for (int k = 14; k <= 18; k++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b1111 || sel !== 2'd2 || tick !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drop_dark k=%0d an=%b sel=%b tick=%b required 1111 10 0", k, an, sel, tick);
            end
        end
        @(negedge clk);
        checks++;
        if (an !== 4'b0111 || sel !== 2'd3 || tick !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_next an=%b sel=%b tick=%b required 0111 11 1", an, sel, tick);
        end
    endtask

    task automatic test_halt_resume;
        do_reset(1'b1, 4'b1111);
        repeat (11) @(negedge clk);
        checks++;
        if (an !== 4'b1111 || sel !== 2'd1) begin
            failures++;
            $display("[TB] FAIL halt_blank an=%b sel=%b required 1111 01", an, sel);
        end
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b1111 || sel !== 2'd1 || tick !== 1'b0) begin
                failures++;
                $display("[TB] FAIL halt_idle k=%0d an=%b sel=%b tick=%b required 1111 01 0", k, an, sel, tick);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (an !== ((k <= 4) ? 4'b1101 : 4'b1111) || sel !== 2'd1 || tick !== 1'b0) begin
                failures++;
                $display("[TB] FAIL resume k=%0d an=%b sel=%b tick=%b required %b 01 0", k, an, sel, tick,
                         (k <= 4) ? 4'b1101 : 4'b1111);
            end
        end
    endtask

    task automatic test_empty_and_single;
        logic [3:0] ea;
        logic       et;
        int ph;
        do_reset(1'b1, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b1111 || tick !== 1'b0 || sel !== 2'd0) begin
                failures++;
                $display("[TB] FAIL empty k=%0d an=%b tick=%b sel=%b required 1111 0 00", k, an, tick, sel);
            end
        end
        mask = 4'b1000;
        @(negedge clk);
        checks++;
        if (an !== 4'b0111 || sel !== 2'd3) begin
            failures++;
            $display("[TB] FAIL single_start an=%b sel=%b required 0111 11", an, sel);
        end
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            ph = (k - 1) % 6;
            ea = (ph < 4) ? 4'b0111 : 4'b1111;
            et = (ph == 0);
            checks++;
            if (an !== ea || sel !== 2'd3 || tick !== et) begin
                failures++;
                $display("[TB] FAIL single k=%0d an=%b sel=%b tick=%b required %b 11 %b", k, an, sel, tick, ea, et);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b1, 4'b0101);
        repeat (7) @(negedge clk);
        checks++;
        if (an !== 4'b1011 || sel !== 2'd2) begin
            failures++;
            $display("[TB] FAIL async_pre an=%b sel=%b required 1011 10", an, sel);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111 || sel !== 2'd0 || tick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_rst an=%b sel=%b tick=%b required 1111 00 0", an, sel, tick);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || sel !== 2'd0) begin
            failures++;
            $display("[TB] FAIL async_after an=%b sel=%b required 1110 00", an, sel);
        end
    endtask

    initial begin
        test_reset();
        test_mask_skip();
        test_mask_drop();
        test_halt_resume();
        test_empty_and_single();
        test_async_reset();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
